mad_frame_rx: RTL and testbench

- Serial-to-parallel receiver for the 20-bit match-result frame {coordinate, mad}, which is sent MSB-first on a 1-bit port by the PE output register.
- Sits at the block-matching array output. Reassembles each frame and presents coordinate/mad with a one-cycle valid strobe to the motion-vector decision logic.
- Flags framing errors.
- Optionally tracks the minimum-MAD candidate.

---
 rtl/fsbm_pkg.sv | 19 +
 rtl/mad_min_tracker.sv | 67 ++++++
 rtl/mad_frame_rx.sv | 150 +++++++++++++++
 tb/tb_mad_frame_rx.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/fsbm_pkg.sv
// Shared definitions for the block-matching result path.
//   COORD_W_DEF / MAD_W_DEF : default field widths of the {coordinate, mad} frame
//   FRAME_W_DEF             : default serial frame length in bits
//   rx_state_e              : serial receiver FSM states
//   MAD_MAX                 : all-ones MAD at default width (empty "best" value)
package fsbm_pkg;

    localparam int unsigned COORD_W_DEF = 8;
    localparam int unsigned MAD_W_DEF   = 12;
    localparam int unsigned FRAME_W_DEF = COORD_W_DEF + MAD_W_DEF;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } rx_state_e;

    localparam logic [MAD_W_DEF-1:0] MAD_MAX = '1;

endpackage

// File: rtl/mad_min_tracker.sv
// Tracks the minimum-MAD candidate seen since reset or the last clear.
// Ports:
//   clk, rst_n        : clock, synchronous active-low reset
//   load              : a new frame is being loaded (same edge as valid rising)
//   best_clear        : restart the minimum search
//   new_coordinate    : coordinate of the frame being loaded
//   new_mad           : MAD of the frame being loaded
//   best_coordinate   : coordinate of the current minimum
//   best_mad          : current minimum MAD (all ones when empty)
//   best_valid        : at least one candidate is held
module mad_min_tracker
    import fsbm_pkg::*;
#(
    parameter int unsigned COORD_W = COORD_W_DEF,
    parameter int unsigned MAD_W   = MAD_W_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load,
    input  logic               best_clear,
    input  logic [COORD_W-1:0] new_coordinate,
    input  logic [MAD_W-1:0]   new_mad,
    output logic [COORD_W-1:0] best_coordinate,
    output logic [MAD_W-1:0]   best_mad,
    output logic               best_valid
);

    logic [COORD_W-1:0] best_coord_q, best_coord_d;
    logic [MAD_W-1:0]   best_mad_q, best_mad_d;
    logic               best_valid_q, best_valid_d;
    logic               take;

    // Strict compare so ties keep the earlier candidate. A clear coinciding
    // with a load makes the new frame the sole candidate.
    always_comb begin
        take         = load && (best_clear || !best_valid_q || (new_mad < best_mad_q));
        best_coord_d = best_coord_q;
        best_mad_d   = best_mad_q;
        best_valid_d = best_valid_q;
        if (take) begin
            best_coord_d = new_coordinate;
            best_mad_d   = new_mad;
            best_valid_d = 1'b1;
        end else if (best_clear) begin
            best_coord_d = '0;
            best_mad_d   = '1;
            best_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            best_coord_q <= '0;
            best_mad_q   <= '1;
            best_valid_q <= 1'b0;
        end else begin
            best_coord_q <= best_coord_d;
            best_mad_q   <= best_mad_d;
            best_valid_q <= best_valid_d;
        end
    end

    assign best_coordinate = best_coord_q;
    assign best_mad        = best_mad_q;
    assign best_valid      = best_valid_q;

endmodule

// File: rtl/mad_frame_rx.sv
// Serial-to-parallel receiver for the {coordinate, mad} match-result frame,
// sent MSB first, one bit per clock.
// Optional feature: define MIN_TRACK_EN to track the minimum-MAD candidate;
// otherwise best_* stay at their reset values and best_clear is ignored.
// Ports:
//   clk, rst_n        : clock, synchronous active-low reset
//   s_in_port         : serial frame data, MSB first
//   frame_start       : high in the cycle s_in_port carries the frame MSB
//   best_clear        : restart minimum search (MIN_TRACK_EN only)
//   coordinate, mad   : last received fields, change only with valid
//   valid             : one-cycle pulse, coordinate/mad updated
//   busy              : frame reception in progress
//   frame_err         : one-cycle pulse, frame aborted by a new frame_start
//   best_coordinate   : coordinate of minimum MAD
//   best_mad          : minimum MAD so far (all ones when empty)
//   best_valid        : best_* holds at least one candidate
module mad_frame_rx
    import fsbm_pkg::*;
#(
    parameter int unsigned COORD_W = COORD_W_DEF,
    parameter int unsigned MAD_W   = MAD_W_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               s_in_port,
    input  logic               frame_start,
    input  logic               best_clear,
    output logic [COORD_W-1:0] coordinate,
    output logic [MAD_W-1:0]   mad,
    output logic               valid,
    output logic               busy,
    output logic               frame_err,
    output logic [COORD_W-1:0] best_coordinate,
    output logic [MAD_W-1:0]   best_mad,
    output logic               best_valid
);

    localparam int unsigned FRAME_W  = COORD_W + MAD_W;
    localparam int unsigned CNT_W    = $clog2(FRAME_W);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_W - 1);

    rx_state_e            state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    // Holds the first FRAME_W-1 bits; the LSB is taken straight from the port.
    logic [FRAME_W-2:0]   shift_q, shift_d;
    logic [FRAME_W-1:0]   frame_word;
    logic [COORD_W-1:0]   coord_q, coord_d;
    logic [MAD_W-1:0]     mad_q, mad_d;
    logic                 valid_q, err_q;
    logic                 load, abort;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        shift_d    = shift_q;
        load       = 1'b0;
        abort      = 1'b0;
        frame_word = {shift_q, s_in_port};
        unique case (state_q)
            IDLE: begin
                if (frame_start) begin
                    state_d = SHIFT;
                    cnt_d   = CNT_W'(1);
                    shift_d = {{(FRAME_W-2){1'b0}}, s_in_port};
                end
            end
            SHIFT: begin
                if (frame_start) begin
                    // Restart: the current bit is the MSB of a new frame.
                    abort   = 1'b1;
                    cnt_d   = CNT_W'(1);
                    shift_d = {{(FRAME_W-2){1'b0}}, s_in_port};
                end else if (cnt_q == LAST_CNT) begin
                    load    = 1'b1;
                    state_d = IDLE;
                    cnt_d   = '0;
                    shift_d = '0;
                end else begin
                    cnt_d   = cnt_q + CNT_W'(1);
                    shift_d = {shift_q[FRAME_W-3:0], s_in_port};
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                shift_d = '0;
            end
        endcase
    end

    always_comb begin
        coord_d = coord_q;
        mad_d   = mad_q;
        if (load) begin
            coord_d = frame_word[FRAME_W-1:MAD_W];
            mad_d   = frame_word[MAD_W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            shift_q <= '0;
            coord_q <= '0;
            mad_q   <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
            coord_q <= coord_d;
            mad_q   <= mad_d;
            valid_q <= load;
            err_q   <= abort;
        end
    end

    assign coordinate = coord_q;
    assign mad        = mad_q;
    assign valid      = valid_q;
    assign frame_err  = err_q;
    assign busy       = (state_q == SHIFT);

`ifdef MIN_TRACK_EN
    // Fed from the load strobe so best_* change on the same edge valid rises.
    mad_min_tracker #(
        .COORD_W (COORD_W),
        .MAD_W   (MAD_W)
    ) u_min_tracker (
        .clk             (clk),
        .rst_n           (rst_n),
        .load            (load),
        .best_clear      (best_clear),
        .new_coordinate  (coord_d),
        .new_mad         (mad_d),
        .best_coordinate (best_coordinate),
        .best_mad        (best_mad),
        .best_valid      (best_valid)
    );
`else
    logic unused_best_clear;
    assign unused_best_clear = best_clear;
    assign best_coordinate   = '0;
    assign best_mad          = '1;
    assign best_valid        = 1'b0;
`endif

endmodule

// File: tb/tb_mad_frame_rx.sv
// Directed bench for mad_frame_rx: single frame, back-to-back frames, aborts,
// mid-frame reset and minimum-MAD tracking (reset values when not built in).
module tb_mad_frame_rx;

`ifdef MIN_TRACK_EN
    localparam bit TRK = 1'b1;
`else
    localparam bit TRK = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        s_in_port;
    logic        frame_start;
    logic        best_clear;
    logic [7:0]  coordinate;
    logic [11:0] mad;
    logic        valid;
    logic        busy;
    logic        frame_err;
    logic [7:0]  best_coordinate;
    logic [11:0] best_mad;
    logic        best_valid;

    int n_tests  = 0;
    int n_fail   = 0;
    int valid_cnt = 0;
    int err_cnt   = 0;
    int busy_bad  = 0;

    always #5 clk = ~clk;

    mad_frame_rx dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .s_in_port       (s_in_port),
        .frame_start     (frame_start),
        .best_clear      (best_clear),
        .coordinate      (coordinate),
        .mad             (mad),
        .valid           (valid),
        .busy            (busy),
        .frame_err       (frame_err),
        .best_coordinate (best_coordinate),
        .best_mad        (best_mad),
        .best_valid      (best_valid)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // One clock: drive inputs, pass the edge, sample 1 ns later.
    task automatic step(input logic b, input logic fs, input logic clr);
        s_in_port   = b;
        frame_start = fs;
        best_clear  = clr;
        @(posedge clk);
        #1;
        s_in_port   = 1'b0;
        frame_start = 1'b0;
        best_clear  = 1'b0;
        if (valid)     valid_cnt++;
        if (frame_err) err_cnt++;
    endtask

    // Drive the top nbits of f MSB first; frame_start on the first bit,
    // best_clear (if asked) on the LSB cycle of a full frame.
    task automatic send_bits(input logic [19:0] f, input int nbits, input logic clr_last);
        for (int i = 0; i < nbits; i++) begin
            step(f[19-i], (i == 0), (clr_last && (i == 19)));
            if (busy !== (i < 19)) busy_bad++;
        end
    endtask

    task automatic clear_counts();
        valid_cnt = 0;
        err_cnt   = 0;
        busy_bad  = 0;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_coord"},      32'(coordinate),      32'h0);
        check({tag, "_mad"},        32'(mad),             32'h0);
        check({tag, "_valid"},      32'(valid),           32'h0);
        check({tag, "_busy"},       32'(busy),            32'h0);
        check({tag, "_err"},        32'(frame_err),       32'h0);
        check({tag, "_best_coord"}, 32'(best_coordinate), 32'h0);
        check({tag, "_best_mad"},   32'(best_mad),        32'hFFF);
        check({tag, "_best_valid"}, 32'(best_valid),      32'h0);
    endtask

    task automatic check_best(input string tag, input logic [7:0] c, input logic [11:0] m,
                              input logic v);
        check({tag, "_best_coord"}, 32'(best_coordinate), TRK ? 32'(c) : 32'h0);
        check({tag, "_best_mad"},   32'(best_mad),        TRK ? 32'(m) : 32'hFFF);
        check({tag, "_best_valid"}, 32'(best_valid),      TRK ? 32'(v) : 32'h0);
    endtask

    logic [19:0] fr;

    initial begin
        rst_n       = 1'b0;
        s_in_port   = 1'b0;
        frame_start = 1'b0;
        best_clear  = 1'b0;
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        check_reset_state("reset");
        rst_n = 1'b1;
        step(1'b0, 1'b0, 1'b0);

        // Single frame: valid 20 cycles after frame_start, busy cycles 1-19.
        clear_counts();
        send_bits(20'hA53C7, 20, 1'b0);
        check("single_valid",    32'(valid),      32'h1);
        check("single_coord",    32'(coordinate), 32'hA5);
        check("single_mad",      32'(mad),        32'h3C7);
        check("single_vcnt",     32'(valid_cnt),  32'h1);
        check("single_errcnt",   32'(err_cnt),    32'h0);
        check("single_busy",     32'(busy_bad),   32'h0);
        step(1'b1, 1'b0, 1'b0);
        check("single_pulse",    32'(valid),      32'h0);
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        check("single_hold",     32'(coordinate), 32'hA5);
        check("single_hold_mad", 32'(mad),        32'h3C7);

        // Back-to-back: second frame_start in the valid cycle of the first.
        clear_counts();
        send_bits(20'h12345, 20, 1'b0);
        check("b2b1_valid", 32'(valid),      32'h1);
        check("b2b1_coord", 32'(coordinate), 32'h12);
        check("b2b1_mad",   32'(mad),        32'h345);
        send_bits(20'hFFFFF, 20, 1'b0);
        check("b2b2_valid", 32'(valid),      32'h1);
        check("b2b2_coord", 32'(coordinate), 32'hFF);
        check("b2b2_mad",   32'(mad),        32'hFFF);
        check("b2b_vcnt",   32'(valid_cnt),  32'h2);
        check("b2b_errcnt", 32'(err_cnt),    32'h0);
        check("b2b_busy",   32'(busy_bad),   32'h0);

        // Abort at bit 7, then a full frame.
        step(1'b0, 1'b0, 1'b0);
        clear_counts();
        send_bits(20'hA53C7, 12, 1'b0);
        send_bits(20'h00001, 20, 1'b0);
        check("abort_errcnt", 32'(err_cnt),    32'h1);
        check("abort_vcnt",   32'(valid_cnt),  32'h1);
        check("abort_coord",  32'(coordinate), 32'h00);
        check("abort_mad",    32'(mad),        32'h001);
        step(1'b0, 1'b0, 1'b0);
        check("abort_errpulse", 32'(frame_err), 32'h0);

        // Abort on the LSB cycle.
        clear_counts();
        send_bits(20'hFFFFF, 19, 1'b0);
        send_bits(20'h00ABC, 20, 1'b0);
        check("lsbabort_errcnt", 32'(err_cnt),    32'h1);
        check("lsbabort_vcnt",   32'(valid_cnt),  32'h1);
        check("lsbabort_coord",  32'(coordinate), 32'h00);
        check("lsbabort_mad",    32'(mad),        32'hABC);

        // Reset for one cycle at bit 10; trailing bits without frame_start are ignored.
        step(1'b0, 1'b0, 1'b0);
        clear_counts();
        fr = 20'hA53C7;
        send_bits(fr, 9, 1'b0);
        rst_n = 1'b0;
        step(fr[10], 1'b0, 1'b0);
        rst_n = 1'b1;
        check_reset_state("midrst");
        for (int i = 9; i >= 0; i--) step(fr[i], 1'b0, 1'b0);
        check("midrst_vcnt",   32'(valid_cnt), 32'h0);
        check("midrst_errcnt", 32'(err_cnt),   32'h0);
        check("midrst_busy",   32'(busy),      32'h0);
        send_bits(20'h5A0F0, 20, 1'b0);
        check("midrst_coord", 32'(coordinate), 32'h5A);
        check("midrst_mad",   32'(mad),        32'h0F0);

        // Minimum tracking: start from an empty search.
        step(1'b0, 1'b0, 1'b1);
        check_best("clr0", 8'h00, 12'hFFF, 1'b0);
        send_bits({8'h11, 12'h300}, 20, 1'b0);
        check_best("min1", 8'h11, 12'h300, 1'b1);
        send_bits({8'h33, 12'h100}, 20, 1'b0);
        check_best("min2", 8'h33, 12'h100, 1'b1);
        send_bits({8'h22, 12'h100}, 20, 1'b0);
        check_best("min_tie", 8'h33, 12'h100, 1'b1);
        send_bits({8'h44, 12'h200}, 20, 1'b0);
        check_best("min4", 8'h33, 12'h100, 1'b1);
        // best_clear sampled on the same edge that raises valid for 0x7FF.
        send_bits({8'h55, 12'h7FF}, 20, 1'b1);
        check("clrload_valid", 32'(valid), 32'h1);
        check_best("clrload", 8'h55, 12'h7FF, 1'b1);
        step(1'b0, 1'b0, 1'b1);
        check_best("clr1", 8'h00, 12'hFFF, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
